// File: rtl/pc_pkg.sv
// pc_pkg: shared state enum, default widths/vectors and the INC alignment mask for pc_gen
package pc_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;
  localparam int XLEN_DEF = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  function automatic logic [63:0] align_mask(input int unsigned inc);
    return ~(64'(inc) - 64'd1);
  endfunction
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC priority mux (trap > redirect > advance > hold) with target alignment; trap path only under PC_TRAP_EN
module pc_next_sel import pc_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int INC = 4
) (
  input  state_t            state,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   pc_inc,
  input  logic              ready,
  input  logic              redirect,
  input  logic [XLEN-1:0]   target,
  input  logic              halt,
`ifdef PC_TRAP_EN
  input  logic              trap,
  input  logic [XLEN-1:0]   trap_vector,
  output logic              trap_take,
`endif
  output logic [XLEN-1:0]   pc_next,
  output logic              jump,
  output logic              misaligned
);
  localparam logic [XLEN-1:0] MASK = XLEN'(align_mask(INC));
  logic active, redir_take, adv;
  logic [XLEN-1:0] jump_tgt;
  assign active = state != BOOT;
`ifdef PC_TRAP_EN
  assign trap_take = active && trap;
  assign redir_take = active && redirect && !trap_take;
  assign jump = trap_take || redir_take;
  assign jump_tgt = trap_take ? trap_vector : target;
`else
  assign redir_take = active && redirect;
  assign jump = redir_take;
  assign jump_tgt = target;
`endif
  assign adv = state == RUN && !halt && ready;
  assign pc_next = jump ? (jump_tgt & MASK) : adv ? pc_inc : pc;
  assign misaligned = redir_take && |(target & ~MASK);
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with BOOT/RUN/HALTED FSM, valid/ready fetch handshake, redirect epoch and misalignment pulse; PC_TRAP_EN adds trap_i/trap_vector_i/epc_o
module pc_gen import pc_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter int INC = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_inc_o,
  output logic            pc_valid_o,
  input  logic            pc_ready_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            halt_i,
`ifdef PC_TRAP_EN
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vector_i,
  output logic [XLEN-1:0] epc_o,
`endif
  output logic            epoch_o,
  output logic            misaligned_o
);
  state_t state;
  logic [XLEN-1:0] pc_next;
  logic jump, mis, go_run;
`ifdef PC_TRAP_EN
  logic trap_take;
`endif
  assign pc_plus_inc_o = pc_o + XLEN'(INC);
  // HALTED is left by any jump or by halt_i dropping; RUN enters HALTED only on halt without a jump
  assign go_run = state == BOOT || jump || !halt_i;
  pc_next_sel #(.XLEN(XLEN), .INC(INC)) u_sel (
    .state(state), .pc(pc_o), .pc_inc(pc_plus_inc_o), .ready(pc_ready_i),
    .redirect(redirect_i), .target(redirect_target_i), .halt(halt_i),
`ifdef PC_TRAP_EN
    .trap(trap_i), .trap_vector(trap_vector_i), .trap_take(trap_take),
`endif
    .pc_next(pc_next), .jump(jump), .misaligned(mis)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= BOOT;
      pc_o <= RESET_VECTOR;
      pc_valid_o <= 1'b0;
      epoch_o <= 1'b0;
      misaligned_o <= 1'b0;
`ifdef PC_TRAP_EN
      epc_o <= '0;
`endif
    end else begin
      state <= go_run ? RUN : HALTED;
      pc_valid_o <= go_run;
      pc_o <= pc_next;
      epoch_o <= epoch_o ^ jump;
      misaligned_o <= mis;
`ifdef PC_TRAP_EN
      if (trap_take) epc_o <= pc_o;
`endif
    end
endmodule
